// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: default widths, opcodes, FSM states.
package exec_pkg;

    localparam int unsigned M_DEF = 32;
    localparam int unsigned N_DEF = 10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_t;

endpackage

// File: rtl/exec_stage_mul.sv
// Iterative shift-add multiplier: M steps, one multiplier bit per clock.
// product is the accumulator including the current step, so it holds the
// full low-M-bit product during the cycle where last is high.
module mul_shift_add #(
    parameter int unsigned M = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] multiplicand,
    input  logic [M-1:0] multiplier,
    output logic         busy,
    output logic         last,
    output logic [M-1:0] product
);

    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    logic [M-1:0]  mcand_q;
    logic [M-1:0]  mplier_q;
    logic [M-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    // Load operands on start, then add/shift once per cycle until the last step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= multiplicand;
            mplier_q <= multiplier;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(M - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Accumulator value after the current step.
    always_comb begin
        product = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    assign busy = busy_q;
    assign last = busy_q && (cnt_q == CW'(M - 1));

endmodule

// File: rtl/exec_stage.sv
// Sequential execute stage: one instruction in flight, reads two operands from
// the register bank, computes an ALU or multiply result, writes it back.
module exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned M = M_DEF,
    parameter int unsigned N = N_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic [N-1:0] rd,
    output logic [N-1:0] rf_addr1,
    output logic [N-1:0] rf_addr2,
    input  logic [M-1:0] rf_data1,
    input  logic [M-1:0] rf_data2,
    output logic         rf_we,
    output logic [N-1:0] rf_addr3,
    output logic [M-1:0] rf_wdata,
    output logic         done
);

    state_t       state_q, state_d;
    logic [2:0]   op_q;
    logic [N-1:0] rs1_q, rs2_q, rd_q;
    logic [M-1:0] opa_q, opb_q;
    logic [M-1:0] result_q;
    logic [M-1:0] alu_res;

    logic         mul_start;
    logic         mul_busy;
    logic         mul_last;
    logic [M-1:0] mul_product;

    // The multiplier loads straight from the bank read ports at the end of
    // READ so its first step lands in the first EXEC cycle.
    assign mul_start = (state_q == S_READ) && (op_q == OP_MUL);

    mul_shift_add #(.M(M)) u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (rf_data1),
        .multiplier   (rf_data2),
        .busy         (mul_busy),
        .last         (mul_last),
        .product      (mul_product)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived handshake/writeback controls.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        rf_we    = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_READ;
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                if (op_q != OP_MUL || mul_last) state_d = S_WB;
            end
            S_WB: begin
                rf_we   = (op_q != OP_NOP);
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle ALU on the captured operands.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = opa_q + opb_q;
            OP_SUB:  alu_res = opa_q - opb_q;
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_SLT:  alu_res = {{(M-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
            default: alu_res = '0;
        endcase
    end

    // Instruction fields, operand capture and result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        rd_q  <= rd;
                    end
                end
                S_READ: begin
                    opa_q <= rf_data1;
                    opb_q <= rf_data2;
                end
                S_EXEC: begin
                    if (op_q != OP_MUL) begin
                        result_q <= alu_res;
                    end else if (mul_busy && mul_last) begin
                        result_q <= mul_product;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_addr1 = rs1_q;
    assign rf_addr2 = rs2_q;
    assign rf_addr3 = rd_q;
    assign rf_wdata = result_q;

endmodule
